// File: rtl/chain_calculator.sv
// Encoder-driven calculator controller: operand entry, op select, ALU compute
// (iterative shift-add multiply) and result display, with optional result chaining.
module chain_calculator #(
  parameter int WIDTH   = 8,
  parameter int MAX_OPS = 4,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value_in,
  input  logic             select_pulse,
  input  logic             restart,
  input  logic             mode_chain,
  output logic             display_load,
  output logic [WIDTH-1:0] display_value,
  output logic             led_flag,
  output logic             busy,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] op_count
);

  localparam int MC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPA     = 3'd1,
    S_OPB     = 3'd2,
    S_OPSEL   = 3'd3,
    S_COMPUTE = 3'd4,
    S_RESULT  = 3'd5
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q, disp_val_q;
  logic [2:0]         op_q;
  logic               flag_q, busy_q, disp_load_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] mul_acc_q;
  logic [MC_W-1:0]    mul_cnt_q;

  logic [WIDTH:0]     add_w;
  logic [WIDTH-1:0]   sh_amt, alu_res;
  logic [2*WIDTH-1:0] shl_w, shr_w, mul_add, mul_acc_d;
  logic               alu_flag, mul_done, chain_ok, go_idle;

  // Single-cycle ALU plus one shift-add step of the multiplier per cycle
  always_comb begin
    add_w     = {1'b0, a_q} + {1'b0, b_q};
    sh_amt    = WIDTH'(32'(b_q) % WIDTH);
    shl_w     = {{WIDTH{1'b0}}, a_q} << sh_amt;
    shr_w     = {a_q, {WIDTH{1'b0}}} >> sh_amt;
    mul_add   = b_q[mul_cnt_q] ? ({{WIDTH{1'b0}}, a_q} << mul_cnt_q) : '0;
    mul_acc_d = mul_acc_q + mul_add;
    mul_done  = (mul_cnt_q == MC_W'(WIDTH - 1));
    alu_res   = '0;
    alu_flag  = 1'b0;
    case (op_q)
      3'd0: begin alu_res = add_w[WIDTH-1:0]; alu_flag = add_w[WIDTH]; end
      3'd1: begin alu_res = a_q - b_q; alu_flag = (a_q < b_q); end
      3'd2: begin alu_res = a_q & b_q; alu_flag = ((a_q & b_q) == '0); end
      3'd3: begin alu_res = a_q | b_q; alu_flag = ((a_q | b_q) == '0); end
      3'd4: begin alu_res = a_q ^ b_q; alu_flag = ((a_q ^ b_q) == '0); end
      3'd5: begin alu_res = shl_w[WIDTH-1:0]; alu_flag = |shl_w[2*WIDTH-1:WIDTH]; end
      3'd6: begin alu_res = shr_w[2*WIDTH-1:WIDTH]; alu_flag = |shr_w[WIDTH-1:0]; end
      default: begin alu_res = mul_acc_d[WIDTH-1:0]; alu_flag = |mul_acc_d[2*WIDTH-1:WIDTH]; end
    endcase
  end

  always_comb begin
    chain_ok = mode_chain && (cnt_q < CNT_W'(MAX_OPS));
    go_idle  = restart || (state_q > S_RESULT) ||
               ((state_q == S_RESULT) && select_pulse && !chain_ok);
  end

  // Display outputs follow the state being entered so they line up with state_out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      flag_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      disp_load_q <= 1'b0;
      disp_val_q  <= '0;
      mul_acc_q   <= '0;
      mul_cnt_q   <= '0;
    end else if (go_idle) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      flag_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      disp_load_q <= 1'b0;
      disp_val_q  <= '0;
      mul_acc_q   <= '0;
      mul_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (select_pulse) begin
            state_q     <= S_OPA;
            disp_load_q <= 1'b1;
            disp_val_q  <= value_in;
          end
        end
        S_OPA: begin
          disp_load_q <= 1'b1;
          disp_val_q  <= value_in;
          if (select_pulse) begin
            a_q     <= value_in;
            state_q <= S_OPB;
          end
        end
        S_OPB: begin
          disp_load_q <= 1'b1;
          if (select_pulse) begin
            b_q        <= value_in;
            state_q    <= S_OPSEL;
            disp_val_q <= {{(WIDTH-3){1'b0}}, value_in[2:0]};
          end else begin
            disp_val_q <= value_in;
          end
        end
        S_OPSEL: begin
          if (select_pulse) begin
            op_q      <= value_in[2:0];
            state_q   <= S_COMPUTE;
            busy_q    <= 1'b1;
            mul_acc_q <= '0;
            mul_cnt_q <= '0;
          end else begin
            disp_val_q <= {{(WIDTH-3){1'b0}}, value_in[2:0]};
          end
        end
        S_COMPUTE: begin
          if ((op_q != 3'd7) || mul_done) begin
            state_q    <= S_RESULT;
            busy_q     <= 1'b0;
            result_q   <= alu_res;
            flag_q     <= alu_flag;
            disp_val_q <= alu_res;
            if (cnt_q < CNT_W'(MAX_OPS)) cnt_q <= cnt_q + 1'b1;
          end else begin
            mul_acc_q <= mul_acc_d;
            mul_cnt_q <= mul_cnt_q + 1'b1;
          end
        end
        S_RESULT: begin
          if (select_pulse) begin
            state_q    <= S_OPB;
            a_q        <= result_q;
            disp_val_q <= value_in;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign display_load  = disp_load_q;
  assign display_value = disp_val_q;
  assign led_flag      = flag_q;
  assign busy          = busy_q;
  assign state_out     = state_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_chain_calculator.sv
// Directed table-driven bench for chain_calculator (WIDTH=8, MAX_OPS=2).
module tb_chain_calculator;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value_in;
  logic       select_pulse, restart, mode_chain;
  logic       display_load, led_flag, busy;
  logic [7:0] display_value;
  logic [2:0] state_out;
  logic [3:0] op_count;

  int nchk  = 0;
  int nfail = 0;

  chain_calculator #(.WIDTH(8), .MAX_OPS(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .select_pulse(select_pulse),
    .restart(restart), .mode_chain(mode_chain), .display_load(display_load),
    .display_value(display_value), .led_flag(led_flag), .busy(busy),
    .state_out(state_out), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       flag;
    int         cyc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_select(input logic [7:0] v);
    value_in     = v;
    select_pulse = 1'b1;
    step();
    select_pulse = 1'b0;
  endtask

  task automatic wait_compute(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      step();
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    do_select(8'h00);
    chk($sformatf("v%0d state_opa", idx), state_out, 1);
    do_select(v.a);
    do_select(v.b);
    chk($sformatf("v%0d opsel_disp", idx), display_value, v.b & 8'h07);
    do_select({5'b0, v.op});
    chk($sformatf("v%0d busy_enter", idx), busy, 1);
    value_in = 8'h5A;
    wait_compute(cyc);
    chk($sformatf("v%0d cycles", idx), cyc, v.cyc);
    chk($sformatf("v%0d result", idx), display_value, v.res);
    chk($sformatf("v%0d flag", idx), led_flag, v.flag);
    chk($sformatf("v%0d op_count", idx), op_count, 1);
    chk($sformatf("v%0d state_res", idx), state_out, 5);
    mode_chain = 1'b0;
    do_select(8'h00);
    chk($sformatf("v%0d back_idle", idx), state_out, 0);
    chk($sformatf("v%0d cnt_clear", idx), op_count, 0);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{8'd200, 8'd100, 3'd0, 8'h2C, 1'b1, 1};
    vecs[1]  = '{8'd5,   8'd9,   3'd1, 8'hFC, 1'b1, 1};
    vecs[2]  = '{8'd9,   8'd5,   3'd1, 8'h04, 1'b0, 1};
    vecs[3]  = '{8'd16,  8'd17,  3'd7, 8'h10, 1'b1, 8};
    vecs[4]  = '{8'd12,  8'd10,  3'd7, 8'h78, 1'b0, 8};
    vecs[5]  = '{8'hFF,  8'hFF,  3'd7, 8'h01, 1'b1, 8};
    vecs[6]  = '{8'h81,  8'd9,   3'd5, 8'h02, 1'b1, 1};
    vecs[7]  = '{8'h01,  8'd7,   3'd5, 8'h80, 1'b0, 1};
    vecs[8]  = '{8'h81,  8'd1,   3'd6, 8'h40, 1'b1, 1};
    vecs[9]  = '{8'h80,  8'd8,   3'd6, 8'h80, 1'b0, 1};
    vecs[10] = '{8'hF0,  8'h0F,  3'd2, 8'h00, 1'b1, 1};
    vecs[11] = '{8'hF0,  8'h0F,  3'd3, 8'hFF, 1'b0, 1};
    vecs[12] = '{8'hAA,  8'hAA,  3'd4, 8'h00, 1'b1, 1};
    vecs[13] = '{8'd1,   8'd2,   3'd0, 8'h03, 1'b0, 1};

    rst = 1'b0; value_in = '0; select_pulse = 1'b0; restart = 1'b0; mode_chain = 1'b0;
    step();
    step();
    chk("rst state", state_out, 0);
    chk("rst display_load", display_load, 0);
    chk("rst display_value", display_value, 0);
    chk("rst flag", led_flag, 0);
    chk("rst busy", busy, 0);
    chk("rst op_count", op_count, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Chained session saturating at two operations
    mode_chain = 1'b1;
    do_select(8'h00);
    do_select(8'd3);
    do_select(8'd4);
    do_select(8'd0);
    wait_compute(cyc);
    chk("chain r1", display_value, 7);
    chk("chain cnt1", op_count, 1);
    do_select(8'h00);
    chk("chain to_opb", state_out, 2);
    chk("chain cnt_hold", op_count, 1);
    do_select(8'd6);
    do_select(8'd7);
    wait_compute(cyc);
    chk("chain mul_cycles", cyc, 8);
    chk("chain r2", display_value, 42);
    chk("chain cnt2", op_count, 2);
    chk("chain flag2", led_flag, 0);
    do_select(8'h00);
    chk("chain sat_idle", state_out, 0);
    chk("chain cnt_clr", op_count, 0);
    chk("chain flag_clr", led_flag, 0);
    chk("chain disp_clr", display_load, 0);
    mode_chain = 1'b0;

    // Restart during the third multiply cycle, with a simultaneous select
    do_select(8'h00);
    do_select(8'd16);
    do_select(8'd17);
    do_select(8'd7);
    step();
    step();
    chk("rs busy_mid", busy, 1);
    restart = 1'b1;
    select_pulse = 1'b1;
    step();
    restart = 1'b0;
    select_pulse = 1'b0;
    chk("rs state", state_out, 0);
    chk("rs busy", busy, 0);
    chk("rs display_load", display_load, 0);
    chk("rs display_value", display_value, 0);
    chk("rs op_count", op_count, 0);
    step();
    chk("rs stay_idle", state_out, 0);

    // Operand entry display follows value_in with one cycle latency
    do_select(8'h00);
    value_in = 8'h3C;
    step();
    chk("disp opa_load", display_load, 1);
    chk("disp opa_val", display_value, 8'h3C);

    // Asynchronous reset in the middle of COMPUTE
    do_select(8'h81);
    do_select(8'd9);
    do_select(8'd5);
    chk("ar busy_pre", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("ar state", state_out, 0);
    chk("ar busy", busy, 0);
    chk("ar display_load", display_load, 0);
    chk("ar display_value", display_value, 0);
    chk("ar flag", led_flag, 0);
    chk("ar op_count", op_count, 0);
    step();
    rst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
